// File: rtl/neogeo_pkg.sv
// Shared types and constants for the NeoGeo sync monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neogeo_pkg;

    localparam int CNT_W  = 10;
    localparam int VCLK_W = 22;
    localparam int ERR_W  = 8;

    // Nominal NeoGeo timing: 320x224 active inside a 384x264 raster.
    localparam int NOM_H_ACTIVE = 320;
    localparam int NOM_V_ACTIVE = 224;
    localparam int NOM_VCLKS    = 101376;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        HOLD     = 2'd3
    } lock_state_t;

    // Per-boundary verdict on the frame that just ended.
    typedef struct packed {
        logic             good;
        logic [CNT_W-1:0] meas_h;
        logic [CNT_W-1:0] meas_v;
    } bnd_info_t;

endpackage

// File: rtl/neogeo_frame_meas.sv
// Measures active width/height per frame and judges each frame good or bad.
// Latency: verdict is combinational in the boundary cycle (frame_change rise).
// Backpressure: none; follows the free-running pixel stream.
module neogeo_frame_meas
    import neogeo_pkg::*;
#(
    parameter int VCLK_TOL = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              de_i,
    input  logic              frame_change_i,
    input  logic [VCLK_W-1:0] vclks_i,
    input  logic [CNT_W-1:0]  h_active_i,
    input  logic [CNT_W-1:0]  v_active_i,
    output logic              bnd_vld_o,
    output bnd_info_t         bnd_o
);

    localparam logic [VCLK_W-1:0] TOL = VCLK_W'(VCLK_TOL);

    logic              de_q, de_d, fc_q, fc_d;
    logic [CNT_W-1:0]  pix_q, pix_d, line_q, line_d, width_q, width_d;
    logic              width_seen_q, width_seen_d, line_bad_q, line_bad_d;
    logic [VCLK_W-1:0] prev_vclks_q, prev_vclks_d;
    logic              prev_valid_q, prev_valid_d;
    logic              de_rise, de_fall, bnd, bad_cap;
    logic [CNT_W-1:0]  width_cap;
    logic [VCLK_W-1:0] vdiff;

    // Edge detection, counters and the frame verdict; a line ending in the
    // boundary cycle is folded into the verdict of the frame it belongs to.
    always_comb begin
        de_d    = de_i;
        fc_d    = frame_change_i;
        de_rise = de_i & ~de_q;
        de_fall = ~de_i & de_q;
        bnd     = frame_change_i & ~fc_q;

        pix_d = pix_q;
        if (de_rise)
            pix_d = CNT_W'(1);
        else if (de_i && (pix_q != CNT_MAX))
            pix_d = pix_q + CNT_W'(1);

        width_cap = (de_fall && !width_seen_q) ? pix_q : width_q;
        bad_cap   = line_bad_q | (de_fall && (pix_q != h_active_i));
        vdiff     = (vclks_i >= prev_vclks_q) ? (vclks_i - prev_vclks_q)
                                              : (prev_vclks_q - vclks_i);

        bnd_vld_o    = bnd;
        bnd_o.meas_h = width_cap;
        bnd_o.meas_v = line_q;
        // A frame without any DE is never good, even if v_active is zero.
        bnd_o.good   = prev_valid_q && !bad_cap && (line_q == v_active_i) &&
                       (line_q != '0) && (vdiff <= TOL);

        width_d      = width_cap;
        width_seen_d = width_seen_q | de_fall;
        line_bad_d   = bad_cap;
        line_d       = line_q;
        if (de_rise && (line_q != CNT_MAX))
            line_d = line_q + CNT_W'(1);
        prev_vclks_d = prev_vclks_q;
        prev_valid_d = prev_valid_q;

        if (bnd) begin
            width_d      = '0;
            width_seen_d = 1'b0;
            line_bad_d   = 1'b0;
            // A line starting on the boundary cycle belongs to the new frame.
            line_d       = de_rise ? CNT_W'(1) : '0;
            prev_vclks_d = vclks_i;
            prev_valid_d = 1'b1;
        end
    end

    // Measurement state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q         <= 1'b0;
            fc_q         <= 1'b0;
            pix_q        <= '0;
            line_q       <= '0;
            width_q      <= '0;
            width_seen_q <= 1'b0;
            line_bad_q   <= 1'b0;
            prev_vclks_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            de_q         <= de_d;
            fc_q         <= fc_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            width_q      <= width_d;
            width_seen_q <= width_seen_d;
            line_bad_q   <= line_bad_d;
            prev_vclks_q <= prev_vclks_d;
            prev_valid_q <= prev_valid_d;
        end
    end

endmodule

// File: rtl/neogeo_sync_monitor.sv
// Lock FSM over frame verdicts; blanks DE/RGB until locked, passes sync.
// Latency: video/sync 1 cycle; status and measurements 1 cycle after boundary.
// Backpressure: none; output stream cannot stall the frontend.
module neogeo_sync_monitor
    import neogeo_pkg::*;
#(
    parameter int LOCK_FRAMES   = 4,
    parameter int UNLOCK_FRAMES = 2,
    parameter int VCLK_TOL      = 256
) (
    input  logic              VCLK_i,
    input  logic              RESET_i,
    input  logic [4:0]        R_i,
    input  logic [4:0]        G_i,
    input  logic [4:0]        B_i,
    input  logic              DARK_i,
    input  logic              HSYNC_i,
    input  logic              VSYNC_i,
    input  logic              DE_i,
    input  logic              frame_change_i,
    input  logic [VCLK_W-1:0] vclks_per_frame_i,
    input  logic [CNT_W-1:0]  h_active_i,
    input  logic [CNT_W-1:0]  v_active_i,
    output logic [4:0]        R_o,
    output logic [4:0]        G_o,
    output logic [4:0]        B_o,
    output logic              DARK_o,
    output logic              HSYNC_o,
    output logic              VSYNC_o,
    output logic              DE_o,
    output logic              locked_o,
    output logic [CNT_W-1:0]  meas_h_o,
    output logic [CNT_W-1:0]  meas_v_o,
    output logic [VCLK_W-1:0] meas_vclks_o,
    output logic [ERR_W-1:0]  err_cnt_o
);

    localparam logic [7:0] LOCK_N   = 8'(LOCK_FRAMES);
    localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_FRAMES);

    logic        bnd_vld;
    bnd_info_t   bnd;

    lock_state_t       state_q, state_d;
    logic [7:0]        cnt_q, cnt_d, cnt_inc;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              err_inc;
    logic [CNT_W-1:0]  meas_h_q, meas_h_d, meas_v_q, meas_v_d;
    logic [VCLK_W-1:0] meas_vclks_q, meas_vclks_d;
    logic              locked, pass_px;
    logic [4:0]        r_q, r_d, g_q, g_d, b_q, b_d;
    logic              dark_q, dark_d, hs_q, hs_d, vs_q, vs_d, vid_de_q, vid_de_d;

    neogeo_frame_meas #(
        .VCLK_TOL(VCLK_TOL)
    ) u_meas (
        .clk            (VCLK_i),
        .rst            (RESET_i),
        .de_i           (DE_i),
        .frame_change_i (frame_change_i),
        .vclks_i        (vclks_per_frame_i),
        .h_active_i     (h_active_i),
        .v_active_i     (v_active_i),
        .bnd_vld_o      (bnd_vld),
        .bnd_o          (bnd)
    );

    assign locked = (state_q == LOCKED) || (state_q == HOLD);

    // Lock FSM next state, evaluated only on frame boundaries.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        err_inc      = 1'b0;
        cnt_inc      = cnt_q + 8'd1;
        meas_h_d     = meas_h_q;
        meas_v_d     = meas_v_q;
        meas_vclks_d = meas_vclks_q;
        if (bnd_vld) begin
            meas_h_d     = bnd.meas_h;
            meas_v_d     = bnd.meas_v;
            meas_vclks_d = vclks_per_frame_i;
            case (state_q)
                UNLOCKED: if (bnd.good) begin
                    cnt_d   = 8'd1;
                    state_d = (LOCK_N <= 8'd1) ? LOCKED : ACQUIRE;
                end
                ACQUIRE: if (bnd.good) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= LOCK_N) state_d = LOCKED;
                end else begin
                    state_d = UNLOCKED;
                end
                LOCKED: if (!bnd.good) begin
                    err_inc = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = (UNLOCK_N <= 8'd1) ? UNLOCKED : HOLD;
                end
                HOLD: if (bnd.good) begin
                    state_d = LOCKED;
                end else begin
                    err_inc = 1'b1;
                    cnt_d   = cnt_inc;
                    if (cnt_inc >= UNLOCK_N) state_d = UNLOCKED;
                end
                default: state_d = UNLOCKED;
            endcase
            if (err_inc && (err_q != '1))
                err_d = err_q + ERR_W'(1);
        end
    end

    // Video gating against the lock state held in the current cycle.
    always_comb begin
        pass_px  = locked & DE_i;
        r_d      = pass_px ? R_i : '0;
        g_d      = pass_px ? G_i : '0;
        b_d      = pass_px ? B_i : '0;
        dark_d   = pass_px & DARK_i;
        vid_de_d = pass_px;
        hs_d     = HSYNC_i;
        vs_d     = VSYNC_i;
    end

    // State, status and video output registers; syncs reset to inactive-high.
    always_ff @(posedge VCLK_i) begin
        if (RESET_i) begin
            state_q      <= UNLOCKED;
            cnt_q        <= '0;
            err_q        <= '0;
            meas_h_q     <= '0;
            meas_v_q     <= '0;
            meas_vclks_q <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            dark_q       <= 1'b0;
            vid_de_q     <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            meas_h_q     <= meas_h_d;
            meas_v_q     <= meas_v_d;
            meas_vclks_q <= meas_vclks_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            dark_q       <= dark_d;
            vid_de_q     <= vid_de_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign R_o          = r_q;
    assign G_o          = g_q;
    assign B_o          = b_q;
    assign DARK_o       = dark_q;
    assign DE_o         = vid_de_q;
    assign HSYNC_o      = hs_q;
    assign VSYNC_o      = vs_q;
    assign locked_o     = locked;
    assign meas_h_o     = meas_h_q;
    assign meas_v_o     = meas_v_q;
    assign meas_vclks_o = meas_vclks_q;
    assign err_cnt_o    = err_q;

endmodule

// File: doc/neogeo_sync_monitor.md
# neogeo_sync_monitor

Validates the timing produced by the NeoGeo frontend and gates its video before it reaches the scaler/output stages. It measures active pixels per line, active lines per frame and VCLKs per frame, and declares lock after a run of consistent frames. It blanks DE and RGB until lock and passes sync through unchanged. Measurements are exported for the OSD and the mode info readout.

## Interface
- LOCK_FRAMES, 4: consecutive good frames required to enter lock (≥1)
- UNLOCK_FRAMES, 2: consecutive bad frames required to drop lock (≥1)
- VCLK_TOL, 256: allowed |Δ vclks_per_frame| between consecutive frames

Ports:
- VCLK_i  in  1  pixel clock; the only clock
- RESET_i  in  1  reset, synchronous and active-high
- R_i, G_i, B_i  in  5 each  pixel colour from frontend
- DARK_i  in  1  dark/shadow flag
- HSYNC_i, VSYNC_i, DE_i  in  1 each  frontend sync/DE (HSYNC/VSYNC active-low)
- frame_change_i  in  1  frame-start flag, high for ≥1 cycle per frame
- vclks_per_frame_i  in  22  last frame length, valid when frame_change_i rises
- h_active_i, v_active_i  in  10 each  expected active size
- R_o, G_o, B_o, DARK_o  out  5/5/5/1  gated video
- HSYNC_o, VSYNC_o, DE_o  out  1 each  delayed sync, gated DE
- locked_o  out  1  lock status
- meas_h_o, meas_v_o  out  10 each  last frame's measured active width/height
- meas_vclks_o  out  22  last frame's vclks_per_frame_i
- err_cnt_o  out  8  saturating count of bad frames seen while locked

## Operation
- Edge detect DE_i and frame_change_i against 1-cycle-delayed copies.
- Pixel counter: cleared to 1 on DE rise, +1 while DE_i high, saturates at 1023. On DE fall, capture the value as the line width. Frame width = first captured line. Set line_bad if any line width ≠ h_active_i.
- Line counter: +1 per DE rise, saturates at 1023.
- Frame boundary = frame_change_i rising edge. A frame is good iff all of:
  - line count == v_active_i
  - line_bad clear
  - prev_valid set
  - |vclks_per_frame_i − prev_vclks| ≤ VCLK_TOL
- At each boundary:
  - latch meas_h_o, meas_v_o, meas_vclks_o
  - prev_vclks ← vclks_per_frame_i; prev_valid ← 1
  - clear line counter and line_bad
- FSM, evaluated only at boundaries:
  - UNLOCKED: good → ACQUIRE (cnt=1), or → LOCKED if LOCK_FRAMES==1
  - ACQUIRE: good → cnt+1; cnt reaching LOCK_FRAMES → LOCKED. Bad → UNLOCKED.
  - LOCKED: bad → HOLD (cnt=1), or → UNLOCKED if UNLOCK_FRAMES==1; err_cnt+1
  - HOLD: good → LOCKED. Bad → cnt+1 and err_cnt+1; cnt reaching UNLOCK_FRAMES → UNLOCKED.
- locked_o = state ∈ {LOCKED, HOLD}.
- Video path:
  - HSYNC_o, VSYNC_o: always pass through.
  - DE_o = DE_i & locked.
  - RGB/DARK_o = inputs when locked & DE_i, else 0.
- err_cnt_o saturates at 255 and clears only on reset.

## Timing
- Video/sync latency: exactly 1 cycle. Gating uses the locked value registered at the previous edge.
- Boundary detected at cycle t (frame_change_i=1, prev=0): state, locked_o, meas_*, err_cnt_o update at t+1.
- Both edges (DE fall and frame_change rise) in the same cycle: the completing line's width and line_bad check count toward the ending frame.
- frame_change_i held high across many cycles: exactly one boundary.
- Frame with no DE: meas_h_o=0, meas_v_o=0, frame bad.
- Reset state (applies to RESET_i at any point, including mid-frame):
  - all outputs 0, except HSYNC_o/VSYNC_o = 1 (inactive)
  - state UNLOCKED, prev_valid=0
  - counters cleared
- RESET_i held: outputs stay in the reset state. The next boundary after release is always bad (prev_valid=0).

## Structure
- neogeo_pkg: lock_state_t enum (UNLOCKED, ACQUIRE, LOCKED, HOLD); width constants (CNT_W=10, VCLK_W=22, ERR_W=8); nominal values 320/224/101376.
- Sub-module neogeo_frame_meas: holds the edge detectors and pixel/line counters and emits a per-boundary {good, meas_h, meas_v} pulse. The top holds the FSM and video gating.

## Test plan
- Reset, then nominal 384×264 frames (320×224 active, vclks 101376): boundary 1 bad; boundaries 2–5 good. locked_o=1 one cycle after boundary 5. meas_h_o=320, meas_v_o=224.
- While locked, one 319-pixel line: next boundary → HOLD, locked_o stays 1, err_cnt_o=1. Following good frame → LOCKED.
- While locked, two consecutive 223-line frames: locked_o=0 after the second boundary. DE_o=0 and RGB=0 from the next cycle. HSYNC_o/VSYNC_o keep toggling.
- Locked, vclks 101376 → 101576 (Δ200): stays LOCKED. Then → 101876 (Δ300): HOLD, err_cnt_o increments.
- RESET_i asserted mid-active-line while locked: all outputs 0 (HSYNC_o/VSYNC_o = 1) the next cycle. After release, relock requires 5 boundaries.
- LOCK_FRAMES=1, UNLOCK_FRAMES=1: locked at boundary 2. One bad frame → UNLOCKED directly. err_cnt_o saturates at 255 under 300 bad locked frames.
